trng_key_buffer: RTL and testbench

//  Downstream consumer of the TRNG/Keccak key output: captures each key_out word via the
//  key_ready/ack_key_read handshake and stores it in a DEPTH-entry FIFO.

---
 rtl/trng_key_buffer.sv | 127 ++++++++++++
 tb/tb_trng_key_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/trng_key_buffer.sv
// Key word buffer between the TRNG/Keccak key output and the bus: a handshake capture FSM
// fills a DEPTH-entry FIFO that the bus drains one word per read request.
module trng_key_buffer #(
    parameter int NBITS_KEY = 32,
    parameter int DEPTH     = 8,
    parameter int LOW_WM    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       key_ready,
    input  logic [NBITS_KEY-1:0]       key_in,
    output logic                       ack_key_read,
    input  logic                       rd_req,
    output logic [NBITS_KEY-1:0]       rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       underflow,
    output logic                       low_wm_intr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LOW_WM_L = LVL_W'(LOW_WM);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t                 state;
    logic [NBITS_KEY-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level_next;
    logic                   capture;
    logic                   wr_en;
    logic                   rd_en;

    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

    // The FSM still advances on a flushed capture; only the data write is dropped.
    assign capture = (state == IDLE) && enable && key_ready && !full;
    assign wr_en   = capture && !flush;
    assign rd_en   = rd_req && !empty && !flush;

    always_comb begin
        level_next = level;
        if (flush)
            level_next = '0;
        else if (wr_en && !rd_en)
            level_next = level + LVL_W'(1);
        else if (rd_en && !wr_en)
            level_next = level - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ack_key_read <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        state        <= ACK;
                        ack_key_read <= 1'b1;
                    end
                end
                ACK: begin
                    state        <= WAIT_LOW;
                    ack_key_read <= 1'b0;
                end
                WAIT_LOW: begin
                    // Upstream holds key_ready until it sees the ack; wait for it to drop
                    // so the same key is not captured twice.
                    if (!key_ready)
                        state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    ack_key_read <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= key_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            underflow   <= 1'b0;
            low_wm_intr <= 1'b0;
        end else begin
            level       <= level_next;
            rd_valid    <= rd_en;
            low_wm_intr <= (level >= LOW_WM_L) && (level_next < LOW_WM_L);
            if (rd_req && empty)
                underflow <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (rd_en) begin
                    rd_data <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_key_buffer.sv
// Scoreboard bench for trng_key_buffer: captured keys queue up as expected read data.
module tb_trng_key_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        key_ready = 1'b0;
    logic [31:0] key_in = '0;
    logic        ack_key_read;
    logic        rd_req = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic        underflow;
    logic        low_wm_intr;

    trng_key_buffer #(.NBITS_KEY(32), .DEPTH(8), .LOW_WM(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .flush        (flush),
        .key_ready    (key_ready),
        .key_in       (key_in),
        .ack_key_read (ack_key_read),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .underflow    (underflow),
        .low_wm_intr  (low_wm_intr)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_rd = '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_ack(input logic [31:0] d);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick;
            if (ack_key_read) got = 1;
        end
        chk("ack_seen", got, 1);
        if (got) begin
            sb_q.push_back(d);
            chk("level_on_ack", level, sb_q.size());
        end
        key_ready = 1'b0;
        tick;
        chk("ack_one_cycle", ack_key_read, 0);
        tick;
    endtask

    task automatic send_key(input logic [31:0] d);
        key_in    = d;
        key_ready = 1'b1;
        wait_ack(d);
    endtask

    task automatic do_read;
        logic [31:0] exp;
        rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, exp);
            last_rd = exp;
        end else begin
            chk("rd_valid_empty", rd_valid, 0);
            chk("rd_data_hold", rd_data, last_rd);
        end
        chk("level_after_rd", level, sb_q.size());
    endtask

    initial begin
        int acks;
        tick; tick;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ack", ack_key_read, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_underflow", underflow, 0);
        rst_n = 1'b1;
        tick;

        // Single capture with key_ready held long after the ack.
        enable = 1'b1; key_ready = 1'b1; key_in = 32'hA5A5_0001;
        tick;
        chk("t1_ack", ack_key_read, 1);
        chk("t1_level", level, 1);
        sb_q.push_back(32'hA5A5_0001);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (ack_key_read) acks++;
        end
        chk("t1_no_reack", acks, 0);
        chk("t1_level_held", level, 1);
        key_ready = 1'b0;
        tick;
        do_read;

        // Fill to full, hold a 9th key, read once, then drain across the wrap.
        for (int k = 1; k <= 8; k++) send_key(32'(k));
        chk("t2_full", full, 1);
        key_in = 32'd9; key_ready = 1'b1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (ack_key_read) acks++;
        end
        chk("t2_no_ack_full", acks, 0);
        do_read;
        wait_ack(32'd9);
        chk("t2_full_again", full, 1);
        for (int i = 0; i < 8; i++) do_read;
        chk("t2_empty", empty, 1);

        // Underflow is sticky across later valid reads.
        do_read;
        chk("t3_underflow", underflow, 1);
        send_key(32'hC0DE_0003);
        do_read;
        chk("t3_underflow_sticky", underflow, 1);

        // Low watermark: 2 -> 1 pulses once, 1 -> 0 does not.
        send_key(32'h4444_0001);
        send_key(32'h4444_0002);
        do_read;
        chk("t4_intr", low_wm_intr, 1);
        tick;
        chk("t4_intr_once", low_wm_intr, 0);
        do_read;
        chk("t4_intr_none", low_wm_intr, 0);

        // Simultaneous capture and read at level 4.
        for (int k = 0; k < 4; k++) send_key(32'h5500_0000 + 32'(k));
        key_in = 32'h5500_00FF; key_ready = 1'b1; rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        chk("t5_ack", ack_key_read, 1);
        chk("t5_rd_valid", rd_valid, 1);
        chk("t5_rd_data", rd_data, sb_q.pop_front());
        sb_q.push_back(32'h5500_00FF);
        chk("t5_level", level, 4);
        key_ready = 1'b0;
        tick; tick;
        for (int i = 0; i < 4; i++) do_read;

        // Flush with a concurrent read while the ack is up.
        send_key(32'h6600_0001);
        send_key(32'h6600_0002);
        key_in = 32'h6600_0003; key_ready = 1'b1;
        tick;
        chk("t6_ack", ack_key_read, 1);
        chk("t6_level3", level, 3);
        flush = 1'b1; rd_req = 1'b1;
        tick;
        flush = 1'b0; rd_req = 1'b0; key_ready = 1'b0;
        sb_q.delete();
        chk("t6_ack_done", ack_key_read, 0);
        chk("t6_level0", level, 0);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_intr", low_wm_intr, 1);
        tick; tick;

        // Reset in the middle of a handshake.
        key_in = 32'h7700_0001; key_ready = 1'b1;
        tick;
        chk("t6_ack2", ack_key_read, 1);
        rst_n = 1'b0; key_ready = 1'b0;
        tick;
        chk("t6r_ack", ack_key_read, 0);
        chk("t6r_level", level, 0);
        chk("t6r_empty", empty, 1);
        chk("t6r_rd_data", rd_data, 0);
        chk("t6r_rd_valid", rd_valid, 0);
        chk("t6r_underflow", underflow, 0);
        chk("t6r_intr", low_wm_intr, 0);
        rst_n = 1'b1;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
